// File: rtl/blk_mem_dp.sv
// rtl/blk_mem_dp.sv - simple dual-port byte-enabled memory with clear sweep
// Sweep zeroes every word after reset or clr_req; port traffic is ignored while busy.
module blk_mem_dp #(
  parameter int BIT_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   wr_en,
  input  logic [BIT_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [BIT_WIDTH-1:0]   wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [BIT_WIDTH-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   addr_err
);

  localparam int                  NB       = BIT_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_ACTIVE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_sweep_cnt;
  logic [ADDR_WIDTH-1:0]   w_sweep_nxt;

  logic [BIT_WIDTH-1:0]    r_mem [DEPTH];

  logic                    w_active;
  logic                    w_wr_in_range;
  logic                    w_rd_in_range;
  logic                    w_wr_ok;
  logic                    w_rd_req;
  logic                    w_err;
  logic [BIT_WIDTH-1:0]    w_rd_word;
  logic                    w_fin_valid;
  logic [BIT_WIDTH-1:0]    w_fin_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_sweep_cnt == LP_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_sweep_nxt = '0;
        end
      end
    endcase
  end

  assign busy          = (r_state == ST_CLEAR);
  assign w_active      = (r_state == ST_ACTIVE);
  assign w_wr_in_range = ({1'b0, addr_in} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, addr_out} < LP_DEPTH);
  assign w_wr_ok       = w_active & wr_en & w_wr_in_range;
  assign w_rd_req      = w_active & rd_en;
  assign w_err         = w_active & ((wr_en & ~w_wr_in_range) | (rd_en & ~w_rd_in_range));

  // The write sampled with clr_req still lands; the sweep starts on the following edge.
  always_ff @(posedge clk) begin
    if (busy) begin
      r_mem[r_sweep_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          r_mem[addr_in][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_req && w_rd_in_range) begin
      w_rd_word = r_mem[addr_out];
      if ((WRITE_FIRST != 0) && w_wr_ok && (addr_in == addr_out)) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                 r_p1_valid;
      logic [BIT_WIDTH-1:0] r_p1_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p1_valid <= 1'b0;
          r_p1_data  <= '0;
        end else begin
          r_p1_valid <= w_rd_req;
          if (w_rd_req) begin
            r_p1_data <= w_rd_word;
          end
        end
      end

      assign w_fin_valid = r_p1_valid;
      assign w_fin_data  = r_p1_data;
    end else begin : g_lat1
      assign w_fin_valid = w_rd_req;
      assign w_fin_data  = w_rd_word;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= w_fin_valid;
      addr_err <= w_err;
      if (w_fin_valid) begin
        rd_data <= w_fin_data;
      end
    end
  end

endmodule

// File: tb/tb_blk_mem_dp.sv
// tb/tb_blk_mem_dp.sv - directed and random checks of blk_mem_dp against a reference model
// Two instances share stimulus: defaults, and DEPTH=12 / RD_LATENCY=2 / WRITE_FIRST=1.
module tb_blk_mem_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [3:0]  addr_in = '0;
  logic [3:0]  addr_out = '0;
  logic [31:0] wr_data = '0;

  logic        busy0, busy1, rv0, rv1, ae0, ae1;
  logic [31:0] rd0, rd1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] m_mem [2][16];
  int          m_rem [2];
  bit          m_sv  [2][4];
  logic [31:0] m_sd  [2][4];
  logic [31:0] e_data [2];
  bit          e_valid [2];
  bit          e_err [2];
  bit          p_err [2];

  blk_mem_dp dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in), .wr_data(wr_data),
    .rd_en(rd_en), .addr_out(addr_out), .rd_data(rd0), .rd_valid(rv0), .addr_err(ae0)
  );

  blk_mem_dp #(.DEPTH(12), .RD_LATENCY(2), .WRITE_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in), .wr_data(wr_data),
    .rd_en(rd_en), .addr_out(addr_out), .rd_data(rd1), .rd_valid(rv1), .addr_err(ae1)
  );

  always #5 clk = ~clk;

  function automatic int dep(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k]   = dep(k);
      e_data[k]  = '0;
      e_valid[k] = 0;
      e_err[k]   = 0;
      p_err[k]   = 0;
      for (int s = 0; s < 4; s++) m_sv[k][s] = 0;
      for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
    end
  endtask

  // Evaluate what the edge about to happen does, from the current inputs.
  task automatic model_pre();
    logic [31:0] v;
    int slot;
    for (int k = 0; k < 2; k++) begin
      p_err[k] = 0;
      if (m_rem[k] > 0) begin
        m_rem[k]--;
      end else begin
        if (rd_en) begin
          v = (int'(addr_out) < dep(k)) ? m_mem[k][addr_out] : 32'h0;
          if (k == 1 && wr_en && addr_in == addr_out && int'(addr_in) < dep(k))
            for (int b = 0; b < 4; b++) if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
          slot = (cyc + lat(k)) % 4;
          m_sv[k][slot] = 1;
          m_sd[k][slot] = v;
        end
        p_err[k] = (wr_en && int'(addr_in) >= dep(k)) || (rd_en && int'(addr_out) >= dep(k));
        if (wr_en && int'(addr_in) < dep(k))
          for (int b = 0; b < 4; b++) if (wr_be[b]) m_mem[k][addr_in][8*b +: 8] = wr_data[8*b +: 8];
        if (clr_req) begin
          for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
          m_rem[k] = dep(k);
        end
      end
    end
  endtask

  task automatic model_post();
    int slot;
    cyc++;
    slot = cyc % 4;
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = m_sv[k][slot];
      if (m_sv[k][slot]) e_data[k] = m_sd[k][slot];
      m_sv[k][slot] = 0;
      e_err[k] = p_err[k];
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, "/busy0"}, 32'(busy0), 32'(m_rem[0] != 0));
    cmp({tag, "/busy1"}, 32'(busy1), 32'(m_rem[1] != 0));
    cmp({tag, "/rv0"},   32'(rv0),   32'(e_valid[0]));
    cmp({tag, "/rv1"},   32'(rv1),   32'(e_valid[1]));
    cmp({tag, "/err0"},  32'(ae0),   32'(e_err[0]));
    cmp({tag, "/err1"},  32'(ae1),   32'(e_err[1]));
    cmp({tag, "/rd0"},   rd0,        e_data[0]);
    cmp({tag, "/rd1"},   rd1,        e_data[1]);
  endtask

  task automatic step(input string tag);
    if (!rst) model_pre();
    @(posedge clk);
    if (!rst) model_post();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic quiet();
    wr_en = 0; rd_en = 0; clr_req = 0; wr_be = '0;
  endtask

  task automatic idle(input int n, input string tag);
    quiet();
    repeat (n) step(tag);
  endtask

  task automatic rand_traffic(input int n, input int clr_odds);
    repeat (n) begin
      wr_en    = 1'($urandom_range(0, 1));
      rd_en    = 1'($urandom_range(0, 1));
      wr_be    = 4'($urandom_range(0, 15));
      addr_in  = 4'($urandom_range(0, 15));
      addr_out = ($urandom_range(0, 3) == 0) ? addr_in : 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      clr_req  = ($urandom_range(1, clr_odds) == 1);
      step("rand");
    end
    quiet();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("reset");

    rst = 1'b0;
    idle(15, "sweep");
    cmp("busy_last_cycle", 32'(busy0), 32'h1);
    idle(1, "sweep_end");
    cmp("busy_dropped", 32'(busy0), 32'h0);

    for (int a = 0; a < 16; a++) begin
      rd_en = 1; addr_out = 4'(a);
      step("zero_read");
    end
    idle(3, "drain");

    wr_en = 1; addr_in = 4'd3; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
    step("be_w1");
    wr_data = 32'h11223344; wr_be = 4'b0101;
    step("be_w2");
    quiet(); rd_en = 1; addr_out = 4'd3;
    step("be_rd");
    cmp("be_merge_lat1", rd0, 32'hAA22CC44);
    quiet();
    step("be_rd2");
    cmp("be_merge_lat2", rd1, 32'hAA22CC44);

    wr_en = 1; addr_in = 4'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1; addr_out = 4'd5;
    step("coll");
    cmp("coll_read_old", rd0, 32'h0);
    cmp("coll_valid_lat1", 32'(rv0), 32'h1);
    quiet();
    step("coll2");
    cmp("coll_read_new", rd1, 32'hFFFFFFFF);
    cmp("coll_valid_lat2", 32'(rv1), 32'h1);

    wr_en = 1; addr_in = 4'd13; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 1; addr_out = 4'd14;
    step("oor_both");
    cmp("oor_single_pulse", 32'(ae1), 32'h1);
    quiet(); wr_en = 1; addr_in = 4'd12; wr_be = 4'hF;
    step("oor_wr");
    quiet(); rd_en = 1; addr_out = 4'd13;
    step("oor_rd");
    idle(3, "oor_drain");
    cmp("oor_rd_zero", rd1, 32'h0);

    rand_traffic(400, 40);
    idle(20, "settle");

    for (int a = 0; a < 16; a++) begin
      wr_en = 1; addr_in = 4'(a); wr_data = 32'h5A5A5A5A; wr_be = 4'hF;
      step("fill");
    end
    quiet(); rd_en = 1; addr_out = 4'd2; clr_req = 1;
    step("clr_rd");
    cmp("clr_pre_data", rd0, 32'h5A5A5A5A);
    cmp("clr_busy", 32'(busy0), 32'h1);
    quiet();
    repeat (16) begin
      wr_en = 1; rd_en = 1; wr_be = 4'hF;
      addr_in = 4'($urandom_range(0, 15)); addr_out = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      step("clr_ignored");
    end
    idle(1, "clr_gap");
    for (int a = 0; a < 16; a++) begin
      rd_en = 1; addr_out = 4'(a);
      step("post_clr_read");
    end
    idle(3, "post_clr_drain");

    clr_req = 1;
    step("clr2");
    quiet();
    idle(7, "sweep_to_7");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    cmp("rst_mid_rv", 32'(rv0), 32'h0);
    cmp("rst_mid_rd", rd0, 32'h0);
    repeat (2) step("rst_hold");
    rst = 1'b0;
    idle(15, "resweep");
    cmp("resweep_busy_full", 32'(busy0), 32'h1);
    idle(1, "resweep_end");

    rand_traffic(200, 60);
    idle(4, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blk_mem_dp.md
BLK_MEM_DP -- requirements
Module: blk_mem_dp

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: data word width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address port width.
REQ-003 SHALL have parameter DEPTH, default 16: number of words; 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter WRITE_FIRST, default 0: same-address collision mode; 0 = read-old, 1 = read-new.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port clr_req, input, 1 bit: request a full memory clear.
REQ-009 SHALL have port busy, output, 1 bit: clear sweep in progress; port accesses ignored while high.
REQ-010 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-011 SHALL have port wr_be, input, BIT_WIDTH/8 bits: byte-lane write enables; bit i covers data bits [8i+7:8i].
REQ-012 SHALL have port addr_in, input, ADDR_WIDTH bits: write address.
REQ-013 SHALL have port wr_data, input, BIT_WIDTH bits: write data.
REQ-014 SHALL have port rd_en, input, 1 bit: read strobe.
REQ-015 SHALL have port addr_out, input, ADDR_WIDTH bits: read address.
REQ-016 SHALL have port rd_data, output, BIT_WIDTH bits: registered read data.
REQ-017 SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data as new.
REQ-018 SHALL have port addr_err, output, 1 bit: one-cycle pulse flagging an out-of-range access.

Function
REQ-019 SHALL have two states: CLEAR and ACTIVE; busy = 1 exactly in CLEAR.
REQ-020 SHALL, in CLEAR, write 0 to word sweep_cnt each cycle, sweep_cnt running 0..DEPTH-1, then enter ACTIVE; sweep lasts exactly DEPTH cycles.
REQ-021 SHALL go from ACTIVE to CLEAR on the cycle after clr_req = 1, with sweep_cnt restarted at 0; clr_req during CLEAR is ignored and does not restart the sweep.
REQ-022 SHALL ignore wr_en and rd_en in CLEAR: no write, no rd_valid, no addr_err.
REQ-023 SHALL, when ACTIVE, wr_en = 1 and addr_in < DEPTH, update only the byte lanes with wr_be[i] = 1; wr_be = 0 leaves the word unchanged.
REQ-024 SHALL, when ACTIVE and rd_en = 1, present the word at addr_out on rd_data with rd_valid = 1 exactly RD_LATENCY cycles later; back-to-back reads give one result per cycle.
REQ-025 SHALL hold rd_data at its last value when no read completes; rd_valid = 0 on those cycles.
REQ-026 SHALL resolve a same-cycle write and read to the same in-range address as follows.
  - WRITE_FIRST = 1: enabled bytes return the new data; disabled bytes return the stored data.
  - WRITE_FIRST = 0: the whole word returns the pre-write value.
REQ-027 SHALL handle addr_in >= DEPTH with wr_en = 1 by dropping the write and pulsing addr_err one cycle later.
REQ-028 SHALL handle addr_out >= DEPTH with rd_en = 1 by returning rd_data = 0 with rd_valid after RD_LATENCY cycles, and pulsing addr_err one cycle after the request.
REQ-029 SHALL produce one addr_err pulse when both accesses in the same cycle are out of range.
REQ-030 SHALL, on the cycle clr_req and wr_en are both sampled in ACTIVE, perform that write before the sweep; reads issued that cycle or earlier complete normally with pre-clear data.
REQ-031 SHALL support DEPTH not a power of two; sweep_cnt and the range checks use DEPTH, not 2^ADDR_WIDTH.

Reset
REQ-032 SHALL, while rst = 1, force rd_data = 0, rd_valid = 0, addr_err = 0, busy = 1, state = CLEAR, sweep_cnt = 0, and flush the read pipeline.
REQ-033 SHALL start the sweep on the first clk edge after rst falls; the memory is zero-filled once busy first drops.
REQ-034 SHALL, on rst asserted mid-sweep or mid-read, discard all in-flight reads and fully restart the sweep after release.

Verification
REQ-035 Reset, defaults: release rst -> busy high for 16 cycles; then reads of addresses 0..15 all return 0 with rd_valid after 1 cycle.
REQ-036 Byte enables, BIT_WIDTH = 32: write 0xAABBCCDD to addr 3 with wr_be = 4'hF, then 0x11223344 with wr_be = 4'b0101 -> reading addr 3 returns 0xAA22CC44.
REQ-037 Collision, addr 5 holds 0x0: same-cycle write of 0xFFFFFFFF (wr_be = 4'hF) and read of addr 5 -> returns 0x0 with WRITE_FIRST = 0, 0xFFFFFFFF with WRITE_FIRST = 1; rd_valid at cycle +1 (RD_LATENCY = 1) or +2 (RD_LATENCY = 2).
REQ-038 Out of range, DEPTH = 12: write to addr 13 -> addr_err pulse, no word changes; read of addr 14 -> rd_data 0, rd_valid 1, addr_err 1.
REQ-039 Clear mid-traffic: fill all words with 0x5A5A5A5A; read addr 2 and assert clr_req in the same cycle -> read returns 0x5A5A5A5A, busy high for DEPTH cycles, wr_en ignored meanwhile, all words read 0 afterwards.
REQ-040 Reset mid-sweep: assert rst at sweep_cnt = 7 -> rd_valid 0, rd_data 0; after release, busy stays high a full DEPTH cycles.
